// File: rtl/pad_dir_seq_pkg.sv
// Shared types and constants for the pad direction sequencer.
package pad_dir_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN,
    ST_DRV,
    ST_SMP,
    ST_RSP
  } pad_seq_state_t;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_RELEASE = 2'b11;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/pad_sync2.sv
// Multi-bit flop-chain synchronizer for the asynchronous pad C returns.
module pad_sync2
  import pad_dir_seq_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/pad_dir_seq.sv
// Direction sequencer for a PADBID pad group with turnaround insertion.
// Optional loopback compare enabled by PAD_DIR_SEQ_LOOPBACK_CHK_EN.
module pad_dir_seq
  import pad_dir_seq_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int TURN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_oen,
  input  logic [WIDTH-1:0] pad_c,
  output logic             chk_err
);

  pad_seq_state_t   state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             pend_rd_q, pend_rd_d;
  logic [WIDTH-1:0] pad_i_q, pad_i_d;
  logic [WIDTH-1:0] pad_oen_q, pad_oen_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] c_sync;
  logic             accept;

  pad_sync2 #(.WIDTH(WIDTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pad_c),
    .q   (c_sync)
  );

  assign accept = cmd_valid & cmd_ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_rd_d = pend_rd_q;
    pad_i_d   = pad_i_q;
    pad_oen_d = pad_oen_q;
    rd_valid_d = rd_valid_q;
    rd_data_d = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && cmd_op == OP_WRITE) begin
          pad_i_d   = cmd_data;
          pend_rd_d = 1'b0;
          cnt_d     = 4'(TURN_CYC - 1);
          state_d   = ST_TURN;
        end else if (accept && cmd_op == OP_READ) begin
          cnt_d   = 4'(SYNC_STAGES - 1);
          state_d = ST_SMP;
        end
      end
      ST_TURN: begin
        if (cnt_q == 4'd0) begin
          if (pend_rd_q) begin
            cnt_d   = 4'(SYNC_STAGES - 1);
            state_d = ST_SMP;
          end else begin
            pad_oen_d = '0;
            state_d   = ST_DRV;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DRV: begin
        if (accept) begin
          case (cmd_op)
            OP_WRITE: pad_i_d = cmd_data;
            OP_READ: begin
              // Release first; the sample only starts after the turnaround.
              pad_oen_d = '1;
              pend_rd_d = 1'b1;
              cnt_d     = 4'(TURN_CYC - 1);
              state_d   = ST_TURN;
            end
            OP_RELEASE: begin
              pad_oen_d = '1;
              state_d   = ST_IDLE;
            end
            default: ;
          endcase
        end
      end
      ST_SMP: begin
        if (cnt_q == 4'd0) begin
          rd_data_d  = c_sync;
          rd_valid_d = 1'b1;
          state_d    = ST_RSP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RSP: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        pad_oen_d = '1;
        state_d   = ST_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_DRV);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_rd_q   <= 1'b0;
      pad_i_q     <= '0;
      pad_oen_q   <= '1;
      cmd_ready_q <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_rd_q   <= pend_rd_d;
      pad_i_q     <= pad_i_d;
      pad_oen_q   <= pad_oen_d;
      cmd_ready_q <= cmd_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

`ifdef PAD_DIR_SEQ_LOOPBACK_CHK_EN
  // stab_q counts earlier DRV cycles with an unchanged pad_i; at 2 the
  // synchronizer has seen the driven value and the compare becomes valid.
  logic [1:0] stab_q, stab_d;
  logic       chk_err_q, chk_err_d;

  always_comb begin
    stab_d = 2'd0;
    if (state_q == ST_DRV && pad_i_d == pad_i_q)
      stab_d = (stab_q == 2'd2) ? 2'd2 : stab_q + 2'd1;
    chk_err_d = chk_err_q |
                ((state_q == ST_DRV) && (stab_q == 2'd2) && (c_sync != pad_i_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_q    <= 2'd0;
      chk_err_q <= 1'b0;
    end else begin
      stab_q    <= stab_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

  assign cmd_ready = cmd_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign pad_i     = pad_i_q;
  assign pad_oen   = pad_oen_q;

endmodule

// File: tb/tb_pad_dir_seq.sv
// Randomized bench for pad_dir_seq against a transaction-level timing model.
module tb_pad_dir_seq;
  import pad_dir_seq_pkg::*;

  localparam int W  = 5;
  localparam int TC = 2;
  localparam logic [W-1:0] ALL1 = '1;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         rd_valid;
  logic         rd_ready;
  logic [W-1:0] rd_data;
  logic [W-1:0] pad_i;
  logic [W-1:0] pad_oen;
  logic [W-1:0] pad_c;
  logic         chk_err;

  int checks = 0;
  int errors = 0;

  // Model: whether the pads are currently driven, and the expected pad_i.
  logic         drv_m;
  logic [W-1:0] pi_m;

  pad_dir_seq #(.WIDTH(W), .TURN_CYC(TC)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .pad_i     (pad_i),
    .pad_oen   (pad_oen),
    .pad_c     (pad_c),
    .chk_err   (chk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] d);
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_data  = W'($urandom);
  endtask

  task automatic do_write(input logic [W-1:0] d);
    $display("txn WRITE data=%0h from_drv=%0d", d, drv_m);
`ifdef PAD_DIR_SEQ_LOOPBACK_CHK_EN
    pad_c = d;
`endif
    issue(OP_WRITE, d);
    check("wr_pad_i", pad_i, d);
    if (drv_m) begin
      check("wr_drv_oen", pad_oen, 0);
      check("wr_drv_ready", cmd_ready, 1);
    end else begin
      check("wr_turn_oen", pad_oen, ALL1);
      check("wr_turn_ready", cmd_ready, 0);
      for (int i = 1; i < TC; i++) begin
        step();
        check("wr_turn_oen", pad_oen, ALL1);
        check("wr_turn_ready", cmd_ready, 0);
      end
      step();
      check("wr_drive_oen", pad_oen, 0);
      check("wr_drive_ready", cmd_ready, 1);
      check("wr_drive_pad_i", pad_i, d);
    end
    drv_m = 1'b1;
    pi_m  = d;
    check("chk_err_clean", chk_err, 0);
  endtask

  task automatic do_read(input logic [W-1:0] v, input int hold);
    int n;
    $display("txn READ padc=%0h from_drv=%0d hold=%0d", v, drv_m, hold);
    pad_c = v;
    step();
    issue(OP_READ, W'($urandom));
    check("rd_rel_oen", pad_oen, ALL1);
    check("rd_ready_low", cmd_ready, 0);
    check("rd_valid_early", rd_valid, 0);
    n = drv_m ? TC + 2 : 2;
    for (int i = 1; i <= n; i++) begin
      step();
      check("rd_valid_timing", rd_valid, (i == n) ? 1 : 0);
      check("rd_wait_oen", pad_oen, ALL1);
    end
    check("rd_data", rd_data, v);
    check("rd_pad_i_kept", pad_i, pi_m);
    for (int i = 0; i < hold; i++) begin
      step();
      check("rd_hold_valid", rd_valid, 1);
      check("rd_hold_data", rd_data, v);
      check("rd_hold_ready", cmd_ready, 0);
    end
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("rd_clear_valid", rd_valid, 0);
    check("rd_clear_ready", cmd_ready, 1);
    drv_m = 1'b0;
  endtask

  task automatic do_release();
    $display("txn RELEASE from_drv=%0d", drv_m);
    issue(OP_RELEASE, W'($urandom));
    check("rel_oen", pad_oen, ALL1);
    check("rel_ready", cmd_ready, 1);
    check("rel_pad_i", pad_i, pi_m);
    drv_m = 1'b0;
  endtask

  task automatic do_nop();
    $display("txn NOP from_drv=%0d", drv_m);
    issue(OP_NOP, W'($urandom));
    check("nop_oen", pad_oen, drv_m ? 0 : ALL1);
    check("nop_pad_i", pad_i, pi_m);
    check("nop_ready", cmd_ready, 1);
  endtask

  task automatic pulse_reset(input string tag);
    $display("txn RESET %s", tag);
    rst = 1'b1;
    #2;
    check("rst_oen", pad_oen, ALL1);
    check("rst_ready", cmd_ready, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_pad_i", pad_i, 0);
    check("rst_chk_err", chk_err, 0);
    rst   = 1'b0;
    drv_m = 1'b0;
    pi_m  = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_no_valid", rd_valid, 0);
      check("post_rst_oen", pad_oen, ALL1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = '0;
    rd_ready  = 1'b0;
    pad_c     = '0;
    drv_m     = 1'b0;
    pi_m      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_oen", pad_oen, ALL1);
    check("reset_pad_i", pad_i, 0);
    check("reset_ready", cmd_ready, 1);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_chk_err", chk_err, 0);
    rst = 1'b0;
    step();

    do_write(5'h15);
    do_write(5'h0A);
    do_release();
    do_read(5'h1F, 4);
    do_write(5'h03);
    do_read(5'h0C, 0);

    $display("txn WRITE data=11 then reset mid-TURN");
    issue(OP_WRITE, 5'h11);
    pulse_reset("mid_turn");

    $display("txn READ then reset mid-SMP");
    issue(OP_READ, 5'h00);
    step();
    pulse_reset("mid_smp");

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: do_nop();
        1: do_write(W'($urandom));
        2: do_read(W'($urandom), int'($urandom_range(0, 4)));
        default: do_release();
      endcase
    end

    do_write(5'h03);
    $display("txn LOOPBACK force pad_c=01 while driving 03");
    pad_c = 5'h01;
    repeat (5) step();
`ifdef PAD_DIR_SEQ_LOOPBACK_CHK_EN
    check("loop_err_set", chk_err, 1);
`else
    check("loop_err_tied", chk_err, 0);
`endif
    pad_c = 5'h03;
    do_release();
    repeat (3) step();
`ifdef PAD_DIR_SEQ_LOOPBACK_CHK_EN
    check("loop_err_sticky", chk_err, 1);
`else
    check("loop_err_tied", chk_err, 0);
`endif
    rst = 1'b1;
    #2;
    check("loop_err_rst", chk_err, 0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
